// File: rtl/counter_bank.sv
// counter_bank: a bank of N_CH independent up/down counters driven by one shared
// programmable prescaler. Each channel can be cleared, stepped manually, or auto-count
// on prescaler ticks, and raises single-cycle zero, compare and wrap event pulses.
//
// Optional feature: define COUNTER_BANK_SNAPSHOT_EN to build the snapshot capture
// registers behind snap_count. Without it, snapshot is ignored and snap_count is 0.
//
// Reset is synchronous and active-high. All state changes on the rising edge of clk.

module counter_bank #(
  parameter int unsigned          N_CH      = 2,
  parameter int unsigned          WIDTH     = 8,
  parameter int unsigned          DIV_WIDTH = 24,
  parameter logic [DIV_WIDTH-1:0] DIV_RESET = 24'h400000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  div_load,
  input  logic [DIV_WIDTH-1:0]  div_value,
  output logic                  tick,
  input  logic [N_CH-1:0]       ch_reset,
  input  logic [N_CH-1:0]       ch_up,
  input  logic [N_CH-1:0]       ch_down,
  input  logic [N_CH-1:0]       ch_auto,
  input  logic [N_CH-1:0]       ch_dir,
  input  logic [N_CH-1:0]       ch_oneshot,
  input  logic [N_CH*WIDTH-1:0] cmp_value,
  output logic [N_CH*WIDTH-1:0] count,
  output logic [N_CH-1:0]       done,
  output logic [N_CH-1:0]       zero_pulse,
  output logic [N_CH-1:0]       cmp_pulse,
  output logic [N_CH-1:0]       wrap_pulse,
  input  logic                  snapshot,
  output logic [N_CH*WIDTH-1:0] snap_count
);

  // ---------------------------------------------------------------------------
  // Shared prescaler
  // ---------------------------------------------------------------------------

  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] reload_q, reload_d;
  logic                 tick_q, tick_d;

  // Down-counter reloads on reaching zero; a load overrides the count and suppresses
  // a new tick that cycle, while a tick already registered still goes out.
  always_comb begin
    reload_d = reload_q;
    div_d    = div_q - DIV_WIDTH'(1);
    tick_d   = 1'b0;
    if (div_load) begin
      reload_d = div_value;
      div_d    = div_value;
    end else if (div_q == '0) begin
      div_d  = reload_q;
      tick_d = 1'b1;
    end
  end

  // Prescaler state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q    <= DIV_RESET;
      reload_q <= DIV_RESET;
      tick_q   <= 1'b0;
    end else begin
      div_q    <= div_d;
      reload_q <= reload_d;
      tick_q   <= tick_d;
    end
  end

  assign tick = tick_q;

  // ---------------------------------------------------------------------------
  // Counter channels
  // ---------------------------------------------------------------------------

  logic [N_CH-1:0][WIDTH-1:0] count_q, count_d;
  logic [N_CH-1:0]            done_q, done_d;
  logic [N_CH-1:0]            wrap_q, wrap_d;
  logic [N_CH-1:0]            zero_pulse_q, cmp_pulse_q;
  logic [N_CH-1:0]            zero_prev_q, cmp_prev_q;
  logic [N_CH-1:0]            zero_now, cmp_now;
  logic [N_CH-1:0]            at_max, at_min;

  // Per-channel level conditions on the current count.
  for (genvar g = 0; g < N_CH; g++) begin : g_match
    assign zero_now[g] = (count_q[g] == '0);
    assign cmp_now[g]  = (count_q[g] == cmp_value[g*WIDTH +: WIDTH]);
    assign at_max[g]   = &count_q[g];
    assign at_min[g]   = ~|count_q[g];
  end

  // Next count: clear > up > down > auto step. A one-shot auto step that would wrap
  // holds at the terminal value and latches done instead.
  always_comb begin
    count_d = count_q;
    done_d  = done_q;
    wrap_d  = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_reset[i]) begin
        count_d[i] = '0;
        done_d[i]  = 1'b0;
      end else if (ch_up[i]) begin
        count_d[i] = count_q[i] + WIDTH'(1);
        wrap_d[i]  = at_max[i];
      end else if (ch_down[i]) begin
        count_d[i] = count_q[i] - WIDTH'(1);
        wrap_d[i]  = at_min[i];
      end else if (ch_auto[i] && tick_q && !done_q[i]) begin
        if (!ch_dir[i]) begin
          if (at_max[i] && ch_oneshot[i]) begin
            done_d[i] = 1'b1;
          end else begin
            count_d[i] = count_q[i] + WIDTH'(1);
            wrap_d[i]  = at_max[i];
          end
        end else begin
          if (at_min[i] && ch_oneshot[i]) begin
            done_d[i] = 1'b1;
          end else begin
            count_d[i] = count_q[i] - WIDTH'(1);
            wrap_d[i]  = at_min[i];
          end
        end
      end
    end
  end

  // Channel state and edge-detected event pulses. Match history resets to 1 so that
  // the all-zero count right after reset does not raise a pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q      <= '0;
      done_q       <= '0;
      wrap_q       <= '0;
      zero_pulse_q <= '0;
      cmp_pulse_q  <= '0;
      zero_prev_q  <= '1;
      cmp_prev_q   <= '1;
    end else begin
      count_q      <= count_d;
      done_q       <= done_d;
      wrap_q       <= wrap_d;
      zero_pulse_q <= zero_now & ~zero_prev_q;
      cmp_pulse_q  <= cmp_now & ~cmp_prev_q;
      zero_prev_q  <= zero_now;
      cmp_prev_q   <= cmp_now;
    end
  end

  assign count      = count_q;
  assign done       = done_q;
  assign wrap_pulse = wrap_q;
  assign zero_pulse = zero_pulse_q;
  assign cmp_pulse  = cmp_pulse_q;

  // ---------------------------------------------------------------------------
  // Snapshot capture
  // ---------------------------------------------------------------------------

`ifdef COUNTER_BANK_SNAPSHOT_EN
  logic [N_CH-1:0][WIDTH-1:0] snap_q;

  // Capture all channels atomically, using the counts from before this edge's update.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_q <= '0;
    end else if (snapshot) begin
      snap_q <= count_q;
    end
  end

  assign snap_count = snap_q;
`else
  logic unused_snapshot;
  assign unused_snapshot = snapshot;
  assign snap_count      = '0;
`endif

endmodule

// File: tb/tb_counter_bank.sv
// Self-checking bench for counter_bank with the default parameters (2 channels of 8 bits).
// A behavioural model written with integer arithmetic tracks the expected outputs;
// directed scenarios follow the intended use cases and a randomized run follows them.

module tb_counter_bank;

  localparam int               N_CH      = 2;
  localparam int               WIDTH     = 8;
  localparam int               DIV_WIDTH = 24;
  localparam logic [23:0]      DIV_RESET = 24'h400000;
  localparam longint           MOD       = 256;
  localparam int               OW        = 1 + 2 * N_CH * WIDTH + 4 * N_CH;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  div_load;
  logic [DIV_WIDTH-1:0]  div_value;
  logic                  tick;
  logic [N_CH-1:0]       ch_reset, ch_up, ch_down, ch_auto, ch_dir, ch_oneshot;
  logic [N_CH*WIDTH-1:0] cmp_value;
  logic [N_CH*WIDTH-1:0] count;
  logic [N_CH-1:0]       done, zero_pulse, cmp_pulse, wrap_pulse;
  logic                  snapshot;
  logic [N_CH*WIDTH-1:0] snap_count;

  int checks = 0;
  int errors = 0;

  counter_bank #(
    .N_CH      (N_CH),
    .WIDTH     (WIDTH),
    .DIV_WIDTH (DIV_WIDTH),
    .DIV_RESET (DIV_RESET)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .div_load   (div_load),
    .div_value  (div_value),
    .tick       (tick),
    .ch_reset   (ch_reset),
    .ch_up      (ch_up),
    .ch_down    (ch_down),
    .ch_auto    (ch_auto),
    .ch_dir     (ch_dir),
    .ch_oneshot (ch_oneshot),
    .cmp_value  (cmp_value),
    .count      (count),
    .done       (done),
    .zero_pulse (zero_pulse),
    .cmp_pulse  (cmp_pulse),
    .wrap_pulse (wrap_pulse),
    .snapshot   (snapshot),
    .snap_count (snap_count)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: integer counts, modulo arithmetic, explicit event rules
  // ---------------------------------------------------------------------------

  longint m_count [N_CH];
  longint m_snap  [N_CH];
  bit     m_done  [N_CH];
  bit     m_zp    [N_CH];
  bit     m_cp    [N_CH];
  bit     m_wp    [N_CH];
  bit     m_zprev [N_CH];
  bit     m_cprev [N_CH];
  bit     m_tick;
  longint m_div, m_reload;

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    bit     t;
    longint c, cv, n;
    if (reset) begin
      m_tick   = 0;
      m_div    = longint'(DIV_RESET);
      m_reload = longint'(DIV_RESET);
      for (int i = 0; i < N_CH; i++) begin
        m_count[i] = 0; m_snap[i] = 0; m_done[i] = 0;
        m_zp[i] = 0; m_cp[i] = 0; m_wp[i] = 0;
        m_zprev[i] = 1; m_cprev[i] = 1;
      end
    end else begin
      t      = m_tick;
      m_tick = (m_div == 0) && !div_load;
      if (div_load) begin
        m_reload = longint'(div_value);
        m_div    = longint'(div_value);
      end else if (m_div == 0) begin
        m_div = m_reload;
      end else begin
        m_div = m_div - 1;
      end
      for (int i = 0; i < N_CH; i++) begin
        c  = m_count[i];
        cv = longint'(cmp_value[i*WIDTH +: WIDTH]);
`ifdef COUNTER_BANK_SNAPSHOT_EN
        if (snapshot) m_snap[i] = c;
`endif
        m_zp[i]    = (c == 0) && !m_zprev[i];
        m_zprev[i] = (c == 0);
        m_cp[i]    = (c == cv) && !m_cprev[i];
        m_cprev[i] = (c == cv);
        m_wp[i]    = 0;
        if (ch_reset[i]) begin
          m_count[i] = 0;
          m_done[i]  = 0;
        end else if (ch_up[i]) begin
          m_count[i] = (c + 1) % MOD;
          m_wp[i]    = (c + 1 == MOD);
        end else if (ch_down[i]) begin
          m_count[i] = (c + MOD - 1) % MOD;
          m_wp[i]    = (c == 0);
        end else if (ch_auto[i] && t && !m_done[i]) begin
          n = ch_dir[i] ? c - 1 : c + 1;
          if (n < 0 || n >= MOD) begin
            if (ch_oneshot[i]) m_done[i] = 1;
            else begin
              m_count[i] = (n + MOD) % MOD;
              m_wp[i]    = 1;
            end
          end else begin
            m_count[i] = n;
          end
        end
      end
    end
  endtask

  function automatic logic [OW-1:0] exp_obs();
    logic [N_CH*WIDTH-1:0] cnt, snp;
    logic [N_CH-1:0]       d, z, cm, w;
    for (int i = 0; i < N_CH; i++) begin
      cnt[i*WIDTH +: WIDTH] = WIDTH'(m_count[i]);
      snp[i*WIDTH +: WIDTH] = WIDTH'(m_snap[i]);
      d[i] = m_done[i]; z[i] = m_zp[i]; cm[i] = m_cp[i]; w[i] = m_wp[i];
    end
    return {m_tick, cnt, d, z, cm, w, snp};
  endfunction

  function automatic logic [OW-1:0] dut_obs();
    return {tick, count, done, zero_pulse, cmp_pulse, wrap_pulse, snap_count};
  endfunction

  // One clock: model and DUT see the same inputs; outputs settle 1 time unit later.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    div_load = 0; div_value = '0; ch_reset = '0; ch_up = '0; ch_down = '0;
    ch_auto = '0; ch_dir = '0; ch_oneshot = '0; snapshot = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------

  task automatic test_reset();
    reset = 1; cycle(); cycle(); reset = 0;
    checks++;
    if (dut_obs() !== '0) begin
      errors++; $display("FAIL reset_state: got %h want 0", dut_obs());
    end
    cycle();
    checks++;
    if (dut_obs() !== exp_obs() || zero_pulse !== '0) begin
      errors++; $display("FAIL reset_no_pulse: got %h want %h", dut_obs(), exp_obs());
    end
  endtask

  task automatic test_prescaler();
    int ticks = 0;
    div_load = 1; div_value = 24'd3; ch_auto[0] = 1; ch_dir[0] = 0;
    cycle();
    div_load = 0;
    for (int k = 1; k <= 21; k++) begin
      cycle();
      if (tick === 1'b1) ticks++;
      checks++;
      if (dut_obs() !== exp_obs()) begin
        errors++; $display("FAIL prescaler_trace k=%0d: got %h want %h", k, dut_obs(), exp_obs());
      end
    end
    checks++;
    if (count[7:0] !== 8'h05 || ticks != 5) begin
      errors++; $display("FAIL prescaler_period: count %h ticks %0d want 05 and 5", count[7:0], ticks);
    end
    // Reload of zero: a tick on every cycle.
    ch_auto = '0; div_load = 1; div_value = '0;
    cycle();
    div_load = 0;
    for (int k = 1; k <= 6; k++) begin
      cycle();
      checks++;
      if (tick !== 1'b1 || dut_obs() !== exp_obs()) begin
        errors++; $display("FAIL prescaler_zero k=%0d: tick %b want 1", k, tick);
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_cnt [4];
    logic       exp_w [4];
    logic       exp_z [4];
    exp_cnt[0] = 8'hFF; exp_cnt[1] = 8'h00; exp_cnt[2] = 8'h01; exp_cnt[3] = 8'h02;
    exp_w[0] = 0; exp_w[1] = 1; exp_w[2] = 0; exp_w[3] = 0;
    exp_z[0] = 0; exp_z[1] = 0; exp_z[2] = 1; exp_z[3] = 0;
    ch_reset[0] = 1; cycle(); ch_reset[0] = 0;
    ch_down[0] = 1; cycle(); cycle(); ch_down[0] = 0;
    cycle(); cycle();
    checks++;
    if (count[7:0] !== 8'hFE || dut_obs() !== exp_obs()) begin
      errors++; $display("FAIL wrap_setup: count %h want fe", count[7:0]);
    end
    ch_auto[0] = 1; ch_dir[0] = 0; ch_oneshot[0] = 0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      checks++;
      if (count[7:0] !== exp_cnt[k] || wrap_pulse[0] !== exp_w[k] || zero_pulse[0] !== exp_z[k]
          || dut_obs() !== exp_obs()) begin
        errors++;
        $display("FAIL wrap_step k=%0d: count %h wrap %b zero %b want %h %b %b",
                 k, count[7:0], wrap_pulse[0], zero_pulse[0], exp_cnt[k], exp_w[k], exp_z[k]);
      end
    end
    ch_auto[0] = 0;
    cycle();
  endtask

  task automatic test_oneshot();
    logic [7:0] exp_cnt [4];
    logic       exp_d [4];
    exp_cnt[0] = 8'h01; exp_cnt[1] = 8'h00; exp_cnt[2] = 8'h00; exp_cnt[3] = 8'h00;
    exp_d[0] = 0; exp_d[1] = 0; exp_d[2] = 1; exp_d[3] = 1;
    ch_reset[1] = 1; cycle(); ch_reset[1] = 0;
    ch_up[1] = 1; cycle(); cycle(); ch_up[1] = 0;
    ch_oneshot[1] = 1; ch_dir[1] = 1; ch_auto[1] = 1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      checks++;
      if (count[15:8] !== exp_cnt[k] || done[1] !== exp_d[k] || wrap_pulse[1] !== 1'b0
          || dut_obs() !== exp_obs()) begin
        errors++;
        $display("FAIL oneshot_step k=%0d: count %h done %b wrap %b want %h %b 0",
                 k, count[15:8], done[1], wrap_pulse[1], exp_cnt[k], exp_d[k]);
      end
    end
    ch_up[1] = 1; cycle(); ch_up[1] = 0;
    checks++;
    if (count[15:8] !== 8'h01 || done[1] !== 1'b1) begin
      errors++; $display("FAIL oneshot_manual: count %h done %b want 01 1", count[15:8], done[1]);
    end
    ch_auto[1] = 0; cycle();
    ch_reset[1] = 1; cycle(); ch_reset[1] = 0;
    checks++;
    if (count[15:8] !== 8'h00 || done[1] !== 1'b0 || dut_obs() !== exp_obs()) begin
      errors++; $display("FAIL oneshot_clear: count %h done %b want 00 0", count[15:8], done[1]);
    end
    ch_oneshot[1] = 0; ch_dir[1] = 0;
  endtask

  task automatic test_priority();
    ch_reset[0] = 1; cycle(); ch_reset[0] = 0;
    ch_up[0] = 1;
    for (int k = 0; k < 16; k++) cycle();
    ch_up[0] = 0; cycle();
    ch_up[0] = 1; ch_down[0] = 1; ch_auto[0] = 1; ch_dir[0] = 0;
    cycle();
    checks++;
    if (count[7:0] !== 8'h11 || tick !== 1'b1) begin
      errors++; $display("FAIL priority_up: count %h want 11", count[7:0]);
    end
    ch_down[0] = 0; ch_reset[0] = 1;
    cycle();
    checks++;
    if (count[7:0] !== 8'h00 || dut_obs() !== exp_obs()) begin
      errors++; $display("FAIL priority_reset: count %h want 00", count[7:0]);
    end
    ch_up[0] = 0; ch_reset[0] = 0; ch_auto[0] = 0;
    cycle();
  endtask

  task automatic test_compare();
    int pulses = 0;
    int at     = -1;
    cmp_value[7:0] = 8'h80;
    ch_reset[0] = 1; cycle(); ch_reset[0] = 0;
    ch_up[0] = 1;
    for (int k = 0; k < 126; k++) cycle();
    ch_up[0] = 0; cycle();
    ch_auto[0] = 1; ch_dir[0] = 0;
    for (int k = 1; k <= 4; k++) begin
      cycle();
      if (cmp_pulse[0] === 1'b1) begin pulses++; at = k; end
    end
    ch_auto[0] = 0;
    cycle(); cycle();
    if (cmp_pulse[0] === 1'b1) pulses++;
    checks++;
    if (pulses != 1 || at != 3 || count[7:0] !== 8'h82) begin
      errors++; $display("FAIL cmp_count: pulses %0d at %0d count %h want 1 3 82", pulses, at, count[7:0]);
    end
    cmp_value[7:0] = WIDTH'(m_count[0]);
    cycle();
    checks++;
    if (cmp_pulse[0] !== 1'b1 || dut_obs() !== exp_obs()) begin
      errors++; $display("FAIL cmp_change: pulse %b want 1", cmp_pulse[0]);
    end
    cycle(); cycle();
    checks++;
    if (cmp_pulse[0] !== 1'b0) begin
      errors++; $display("FAIL cmp_hold: pulse %b want 0", cmp_pulse[0]);
    end
  endtask

  task automatic test_snapshot_reset();
    logic [15:0] exp_snap;
    bit          tick_seen = 0;
`ifdef COUNTER_BANK_SNAPSHOT_EN
    exp_snap = 16'h3344;
`else
    exp_snap = 16'h0000;
`endif
    ch_reset = '1; cycle(); ch_reset = '0;
    for (int k = 0; k < 8'h44; k++) begin
      ch_up[0] = 1; ch_up[1] = (k < 8'h33);
      cycle();
    end
    ch_up = '0;
    snapshot = 1; cycle(); snapshot = 0;
    checks++;
    if (count !== 16'h3344 || snap_count !== exp_snap) begin
      errors++; $display("FAIL snap_capture: count %h snap %h want 3344 %h", count, snap_count, exp_snap);
    end
    ch_up = '1;
    for (int k = 0; k < 3; k++) cycle();
    ch_up = '0;
    checks++;
    if (snap_count !== exp_snap || dut_obs() !== exp_obs()) begin
      errors++; $display("FAIL snap_hold: snap %h want %h", snap_count, exp_snap);
    end
    reset = 1; ch_up = '1; ch_auto = '1; snapshot = 1; div_load = 1; div_value = 24'd1;
    cycle();
    reset = 0; clear_inputs();
    checks++;
    if (dut_obs() !== '0) begin
      errors++; $display("FAIL reset_midrun: got %h want 0", dut_obs());
    end
    for (int k = 0; k < 50; k++) begin
      cycle();
      if (tick !== 1'b0) tick_seen = 1;
    end
    checks++;
    if (tick_seen || dut_obs() !== exp_obs()) begin
      errors++; $display("FAIL reset_prescaler: tick seen %b want 0", tick_seen);
    end
  endtask

  task automatic test_random();
    div_load = 1; div_value = DIV_WIDTH'($urandom_range(0, 3));
    cycle();
    div_load = 0;
    for (int k = 0; k < 1500; k++) begin
      reset     = ($urandom % 400) == 0;
      div_load  = ($urandom % 80) == 0 || reset;
      div_value = DIV_WIDTH'($urandom_range(0, 3));
      snapshot  = ($urandom % 10) == 0;
      for (int i = 0; i < N_CH; i++) begin
        ch_reset[i]   = ($urandom % 40) == 0;
        ch_up[i]      = ($urandom % 5) == 0;
        ch_down[i]    = ($urandom % 5) == 0;
        ch_auto[i]    = ($urandom % 3) != 0;
        ch_dir[i]     = ($urandom % 8) == 0 ? ~ch_dir[i] : ch_dir[i];
        ch_oneshot[i] = ($urandom % 16) == 0 ? ~ch_oneshot[i] : ch_oneshot[i];
        if (($urandom % 8) == 0) begin
          cmp_value[i*WIDTH +: WIDTH] = ($urandom % 2) ? WIDTH'(m_count[i]) : WIDTH'($urandom);
        end
      end
      cycle();
      checks++;
      if (dut_obs() !== exp_obs()) begin
        errors++; $display("FAIL random k=%0d: got %h want %h", k, dut_obs(), exp_obs());
      end
    end
    reset = 0;
    clear_inputs();
  endtask

  initial begin
    reset = 1;
    cmp_value = '0;
    clear_inputs();
    test_reset();
    test_prescaler();
    test_wrap();
    test_oneshot();
    test_priority();
    test_compare();
    test_snapshot_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
